// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX arbiter: FSM state encoding,
// CTRL_REG bit positions and register offsets used by the surrounding bus logic.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  localparam int CTRL_TX_EN_BIT   = 0;
  localparam int CTRL_RX_EN_BIT   = 3;
  localparam int REG_CTRL_OFFS    = 'h0;
  localparam int REG_TX_DATA_OFFS = 'h2;
  localparam int REG_RX_DATA_OFFS = 'h3;

endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// Combinational round-robin picker: first set bit of valid_i scanning from ptr_i
// upward with wrap; reports one-hot grant, encoded index and whether anything won.
module rr_priority_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_o,
  output logic [N-1:0]     grant_oh_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    found       = 1'b0;
    idx         = '0;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDX_W'((int'(ptr_i) + k) % N);
      if (!found && valid_i[idx]) begin
        found            = 1'b1;
        grant_oh_o[idx]  = 1'b1;
        grant_idx_o      = idx;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters: round-robin grant with an
// optional per-requester packet lock, then start / wait-rise / wait-fall sequencing of each byte.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int START_TMO = 4096
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         tx_en,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_start,
  output logic [DATA_W-1:0]            tx_data,
  input  logic                         tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         arb_busy,
  output logic                         err_tmo,
  output arb_state_e                   dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(START_TMO);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TMO - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gid_q, gid_d;
  logic                lock_q, lock_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic [NUM_REQ-1:0]  gid_oh, eligible, pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any, pick_last, grant_go, tmo_hit;
  logic [DATA_W-1:0]   pick_data;

  // While locked only the current owner may win, whatever the pointer says.
  always_comb begin
    gid_oh         = '0;
    gid_oh[gid_q]  = 1'b1;
    eligible       = lock_q ? (req_valid & gid_oh) : req_valid;
  end

  rr_priority_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .valid_i     (eligible),
    .ptr_i       (ptr_q),
    .any_o       (pick_any),
    .grant_oh_o  (pick_oh),
    .grant_idx_o (pick_idx)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) pick_data = pick_data | req_data[i*DATA_W +: DATA_W];
    end
    pick_last = |(pick_oh & req_last);
  end

  // Handshake: requester i's byte is consumed on the rising edge where
  // req_valid[i] & req_ready[i]; ready is one-hot, IDLE-only, and never during reset.
  assign grant_go = (state_q == ST_IDLE) && tx_en && pick_any && !PRESET;
  assign tmo_hit  = (state_q == ST_WAIT_BUSY) && !tx_busy && (cnt_q == TMO_LAST);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      lock_q  <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    lock_d  = lock_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (!tx_en) begin
          lock_d = 1'b0;
        end else if (grant_go) begin
          data_d  = pick_data;
          gid_d   = pick_idx;
          lock_d  = !pick_last;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_hit) begin
          lock_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
          if (!lock_q) ptr_d = (gid_q == IDX_LAST) ? '0 : gid_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (grant_go) req_ready = pick_oh;
    tx_start  = (state_q == ST_START);
    arb_busy  = (state_q != ST_IDLE);
    err_tmo   = tmo_hit;
  end

  assign tx_data   = data_q;
  assign grant_id  = gid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requesters, a BCLK-style busy model
// and a scoreboard of expected {grant_id, tx_data} checked at every tx_start.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int START_TMO = 64;
  localparam int IDX_W     = 2;
  localparam int W         = IDX_W + DATA_W;

  logic                      PCLK;
  logic                      PRESET;
  logic                      tx_en;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic [IDX_W-1:0]          grant_id;
  logic                      arb_busy;
  logic                      err_tmo;
  arb_state_e                dbg_state;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .START_TMO(START_TMO)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .tx_en     (tx_en),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .arb_busy  (arb_busy),
    .err_tmo   (err_tmo),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  exp_q[$];
  logic [8:0]    src_q[NUM_REQ][$];
  logic [NUM_REQ-1:0] acc;
  bit   model_on;
  bit   model_kill;
  int   rise_cnt, hold_cnt;
  int   cyc, start_cyc, tmo_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic push_src(input int r, input logic last, input logic [7:0] d);
    src_q[r].push_back({last, d});
  endtask

  task automatic push_exp(input logic [IDX_W-1:0] g, input logic [7:0] d);
    exp_q.push_back({g, d});
  endtask

  function automatic bit tb_idle();
    bit e;
    e = (exp_q.size() == 0) && (acc == '0) && !arb_busy;
    for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_idle(input int budget, input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge PCLK); #3;
      if (tb_idle()) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_state(input arb_state_e s, input int budget, input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge PCLK); #3;
      if (dbg_state == s) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // requesters, busy model and scoreboard monitor, all stepped once per cycle
  initial begin
    logic [8:0] ent;
    acc = '0; rise_cnt = 0; hold_cnt = 0; cyc = 0; start_cyc = 0; tmo_count = 0;
    forever begin
      @(negedge PCLK);
      #1;
      if (model_kill) begin
        rise_cnt = 0; hold_cnt = 0; tx_busy = 1'b0;
      end else begin
        if (hold_cnt > 0) begin
          hold_cnt--;
          if (hold_cnt == 0) tx_busy = 1'b0;
        end
        if (rise_cnt > 0) begin
          rise_cnt--;
          if (rise_cnt == 0) begin tx_busy = 1'b1; hold_cnt = 100; end
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) begin void'(src_q[i].pop_front()); acc[i] = 1'b0; end
        if (src_q[i].size() > 0) begin
          ent = src_q[i][0];
          req_valid[i] = 1'b1;
          req_last[i]  = ent[8];
          req_data[i*DATA_W +: DATA_W] = ent[7:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
          req_data[i*DATA_W +: DATA_W] = '0;
        end
      end
      #1;
      cyc++;
      for (int i = 0; i < NUM_REQ; i++) acc[i] = req_valid[i] & req_ready[i] & !PRESET;
      if (tx_start === 1'b1) begin
        start_cyc = cyc;
        if (model_on && !model_kill) rise_cnt = 3;
        if (exp_q.size() == 0) check("unexpected_tx_start", 32'd1, 32'd0);
        else check("tx_grant_data", 32'({grant_id, tx_data}), 32'(exp_q.pop_front()));
      end
      if (err_tmo === 1'b1) begin
        tmo_count++;
        check("tmo_latency", 32'(cyc - start_cyc), 32'(START_TMO));
      end
    end
  end

  initial begin
    PRESET = 1'b1; tx_en = 1'b1; tx_busy = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    model_on = 1'b1; model_kill = 1'b0;

    // 1: reset held with every requester valid
    push_src(0, 1'b1, 8'h11); push_src(0, 1'b1, 8'h11);
    push_src(1, 1'b1, 8'h22); push_src(2, 1'b1, 8'h33); push_src(3, 1'b1, 8'h44);
    repeat (5) @(negedge PCLK);
    #3;
    check("rst_req_valid_all", 32'(req_valid), 32'hF);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_arb_busy", 32'(arb_busy), 32'd0);
    check("rst_err_tmo", 32'(err_tmo), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // 2: round robin over four always-valid requesters
    push_exp(0, 8'h11); push_exp(1, 8'h22); push_exp(2, 8'h33);
    push_exp(3, 8'h44); push_exp(0, 8'h11);
    @(negedge PCLK);
    PRESET = 1'b0;
    wait_idle(1500, "rr_done");

    // 3: requester 1 locks for a three-byte packet while 0 and 2 wait
    push_src(1, 1'b0, 8'hA0); push_src(1, 1'b0, 8'hA1); push_src(1, 1'b1, 8'hA2);
    push_src(0, 1'b1, 8'h50); push_src(2, 1'b1, 8'h60);
    push_exp(1, 8'hA0); push_exp(1, 8'hA1); push_exp(1, 8'hA2);
    push_exp(2, 8'h60); push_exp(0, 8'h50);
    wait_idle(1500, "lock_done");

    // 4: busy never rises for requester 1; requester 2 is served afterwards
    model_on = 1'b0;
    push_src(1, 1'b1, 8'h77); push_src(2, 1'b1, 8'h88);
    push_exp(1, 8'h77); push_exp(2, 8'h88);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 300 && !seen; k++) begin
        @(negedge PCLK); #3;
        if (tmo_count != 0) seen = 1'b1;
      end
      check("tmo_seen", 32'(seen), 32'd1);
    end
    @(negedge PCLK);
    model_on = 1'b1;
    #3;
    check("tmo_back_idle", 32'(arb_busy), 32'd0);
    check("tmo_pulse_one_cycle", 32'(err_tmo), 32'd0);
    wait_idle(400, "tmo_next_served");

    // 5: tx_en dropped while the byte is on the line
    push_src(3, 1'b1, 8'h99); push_src(0, 1'b1, 8'hAA); push_src(2, 1'b1, 8'hBB);
    push_exp(3, 8'h99);
    wait_state(ST_WAIT_DONE, 50, "txen_reach_wait_done");
    @(negedge PCLK);
    tx_en = 1'b0;
    wait_state(ST_IDLE, 300, "txen_byte_completes");
    repeat (20) @(negedge PCLK);
    #3;
    check("txen_no_ready", 32'(req_ready), 32'd0);
    check("txen_stays_idle", 32'(arb_busy), 32'd0);
    push_exp(0, 8'hAA); push_exp(2, 8'hBB);
    @(negedge PCLK);
    tx_en = 1'b1;
    wait_idle(600, "txen_resume");

    // 6: reset while waiting for busy, with a packet lock taken
    push_src(3, 1'b0, 8'hCC);
    push_exp(3, 8'hCC);
    wait_state(ST_WAIT_BUSY, 50, "mrst_reach_wait_busy");
    @(negedge PCLK);
    PRESET = 1'b1; model_kill = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    #3;
    check("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mrst_grant_id", 32'(grant_id), 32'd0);
    check("mrst_arb_busy", 32'(arb_busy), 32'd0);
    @(negedge PCLK);
    model_kill = 1'b0;
    push_src(1, 1'b1, 8'hDD);
    push_exp(1, 8'hDD);
    wait_idle(400, "mrst_lock_cleared");

    check("tmo_pulse_count", 32'(tmo_count), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
